// File: rtl/tile_wavefront_sched.sv
// Wavefront sequencer for a ROWSxCOLS output-stationary systolic tile.
// One pass: operand stream + diagonal drain, row-wise store, one-cycle done.
module tile_wavefront_sched #(
  parameter int ROWS = 5,
  parameter int COLS = 5,
  parameter int K_BW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [K_BW-1:0]        i_k_len,
  input  logic                   i_abort,
  input  logic                   i_feed_valid,
  output logic                   o_feed_req,
  output logic [ROWS*COLS-1:0]   o_pe_en,
  output logic [ROWS+COLS-2:0]   o_mul_en,
  output logic [ROWS-1:0]        o_str_en,
  output logic                   o_ready,
  output logic                   o_done
);

  localparam int ND = ROWS + COLS - 1;
  localparam int CW = K_BW + 1 + $clog2(ROWS + COLS);

  typedef enum logic [1:0] {IDLE, STREAM, STORE, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [K_BW-1:0] k, k_nxt;
  logic [CW-1:0]   k_ext, last_cnt;
  logic            stall;

  assign k_ext    = CW'(k);
  // Final stream step is index k+ROWS+COLS-3: the last diagonal's last product.
  assign last_cnt = k_ext + CW'(ND - 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      k     <= k_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    k_nxt      = k;
    stall      = 1'b0;
    o_feed_req = 1'b0;
    o_pe_en    = '0;
    o_mul_en   = '0;
    o_str_en   = '0;
    o_ready    = 1'b0;
    o_done     = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start) begin
          if (i_k_len != '0) begin
            k_nxt     = i_k_len;
            cnt_nxt   = '0;
            state_nxt = STREAM;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      STREAM: begin
        o_feed_req = (cnt < k_ext);
        stall      = o_feed_req & ~i_feed_valid;
        if (!stall) begin
          o_pe_en = '1;
          for (int d = 0; d < ND; d++)
            o_mul_en[d] = (cnt >= CW'(d)) && (cnt < CW'(d) + k_ext);
          if (cnt == last_cnt) begin
            cnt_nxt   = '0;
            state_nxt = STORE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      STORE: begin
        o_str_en = ROWS'(1) << cnt;
        if (cnt == CW'(ROWS - 1)) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort only redirects the next state; this cycle's outputs stay state-decoded.
    if (i_abort && state != IDLE) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

endmodule

// File: tb/tb_tile_wavefront_sched.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs, negedge monitor compares.
module tb_tile_wavefront_sched;

  localparam int ROWS = 5;
  localparam int COLS = 5;
  localparam int K_BW = 8;
  localparam int ND   = ROWS + COLS - 1;

  typedef struct packed {
    logic                 ready;
    logic                 done;
    logic                 feed_req;
    logic [ROWS*COLS-1:0] pe;
    logic [ND-1:0]        mul;
    logic [ROWS-1:0]      str;
  } out_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_start;
  logic [K_BW-1:0]      i_k_len;
  logic                 i_abort;
  logic                 i_feed_valid;
  logic                 o_feed_req;
  logic [ROWS*COLS-1:0] o_pe_en;
  logic [ND-1:0]        o_mul_en;
  logic [ROWS-1:0]      o_str_en;
  logic                 o_ready;
  logic                 o_done;

  int   vectors     = 0;
  int   miscompares = 0;
  out_t exp_q[$];

  always #5 clk = ~clk;

  tile_wavefront_sched #(.ROWS(ROWS), .COLS(COLS), .K_BW(K_BW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_k_len(i_k_len), .i_abort(i_abort),
    .i_feed_valid(i_feed_valid), .o_feed_req(o_feed_req), .o_pe_en(o_pe_en),
    .o_mul_en(o_mul_en), .o_str_en(o_str_en), .o_ready(o_ready), .o_done(o_done)
  );

  function automatic out_t idle_o();
    out_t o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  function automatic out_t done_o();
    out_t o = '0;
    o.done = 1'b1;
    return o;
  endfunction

  // Step p of the stream: diagonal d multiplies during steps d..d+k-1.
  function automatic out_t stream_o(input int p, input int k, input bit st);
    out_t o = '0;
    o.feed_req = (p < k);
    if (!st) begin
      o.pe = '1;
      for (int d = 0; d < ND; d++) o.mul[d] = (p >= d) && (p < d + k);
    end
    return o;
  endfunction

  function automatic out_t store_o(input int q);
    out_t o = '0;
    o.str = ROWS'(1) << q;
    return o;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      out_t e, a;
      e = exp_q.pop_front();
      a = '{o_ready, o_done, o_feed_req, o_pe_en, o_mul_en, o_str_en};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL out_vec #%0d: got rdy=%b done=%b req=%b pe=%h mul=%h str=%b, want rdy=%b done=%b req=%b pe=%h mul=%h str=%b",
                 vectors, a.ready, a.done, a.feed_req, a.pe, a.mul, a.str,
                 e.ready, e.done, e.feed_req, e.pe, e.mul, e.str);
      end
    end
  end

  task automatic drive(input bit s, input int kl, input bit ab, input bit fv, input bit r);
    i_start      = s;
    i_k_len      = K_BW'(kl);
    i_abort      = ab;
    i_feed_valid = fv;
    rst          = r;
  endtask

  // One pass started at cycle offset 0. Offsets (-1 = unused) pick cycles for
  // feed_valid drops, spurious starts, abort and reset.
  task automatic run_pass(input int k, input int stall_a, input int stall_b,
                          input int drain_low, input int restart_a, input int restart_b,
                          input int abort_at, input int rst_at, input bit abort_at_start);
    int L = k + ROWS + COLS - 2;
    int s = 0;
    int j = 1;
    bit fin = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, k, abort_at_start, 1'b1, 1'b0);
    exp_q.push_back(idle_o());
    while (!fin) begin
      out_t e;
      bit   low;
      int   p;
      @(posedge clk); #1;
      low = (j == stall_a) || (j == stall_b) || (j == drain_low);
      p = j - 1 - s;
      if (k == 0) begin
        if (j == 1) e = done_o();
        else begin e = idle_o(); fin = 1'b1; end
      end else if (p < L) begin
        bit st = ((j == stall_a) || (j == stall_b)) && (p < k);
        e = stream_o(p, k, st);
        if (st) s++;
      end else if (p - L < ROWS) begin
        e = store_o(p - L);
      end else if (p - L == ROWS) begin
        e = done_o();
      end else begin
        e = idle_o();
        fin = 1'b1;
      end
      if (fin) drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
      else drive((j == restart_a) || (j == restart_b), $urandom_range(0, 255),
                 j == abort_at, !low, j == rst_at);
      exp_q.push_back(e);
      if (!fin && (j == abort_at || j == rst_at)) begin
        @(posedge clk); #1;
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(idle_o());
        fin = 1'b1;
      end
      j++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    exp_q.push_back(idle_o());
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(idle_o());

    // K=3 nominal: done 17 cycles after start
    run_pass(3, -1, -1, -1, -1, -1, -1, -1, 1'b0);
    // K=3 with one stall during the feed window
    run_pass(3, 2, -1, -1, -1, -1, -1, -1, 1'b0);
    // K=0: straight to DONE
    run_pass(0, -1, -1, -1, -1, -1, -1, -1, 1'b0);
    // Abort mid-stream, then a fresh pass
    run_pass(3, -1, -1, -1, -1, -1, 5, -1, 1'b0);
    run_pass(2, -1, -1, -1, -1, -1, -1, -1, 1'b0);
    // Spurious starts in STREAM/STORE, feed_valid low in drain, abort with start in IDLE
    run_pass(3, -1, -1, 7, 4, 13, -1, -1, 1'b1);
    // K=1 two consecutive stalls on the only feed step
    run_pass(1, 1, 2, -1, -1, -1, -1, -1, 1'b0);
    // Abort during STORE
    run_pass(4, -1, -1, -1, -1, -1, 15, -1, 1'b0);
    // K=255 full pass, then reset mid-stream
    run_pass(255, -1, -1, -1, -1, -1, -1, -1, 1'b0);
    run_pass(255, 50, -1, -1, 120, -1, -1, 100, 1'b0);
    run_pass(3, -1, -1, -1, -1, -1, -1, -1, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left, want 0", exp_q.size());
    end
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
